// File: rtl/playbus_pkg.sv
// Shared types for the play-bus burst controller: FSM states, function codes,
// source selection and the ADD region map.
package playbus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SOURCE  = 3'd1,
    ST_WRITE   = 3'd2,
    ST_HOLD    = 3'd3,
    ST_WAIT_GO = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    F_RD_ROM   = 3'd0,
    F_RD_RAM   = 3'd1,
    F_RD_SW    = 3'd2,
    F_SW2RAM   = 3'd3,
    F_ROM2RAM  = 3'd4,
    F_SW2LED   = 3'd5,
    F_ROM2LED  = 3'd6,
    F_RAM2LED  = 3'd7
  } func_t;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_ROM  = 2'd1,
    SRC_RAM  = 2'd2,
    SRC_SW   = 2'd3
  } src_t;

  localparam logic [1:0] REGION_ROM  = 2'b00;
  localparam logic [1:0] REGION_RAM  = 2'b01;
  localparam logic [1:0] REGION_SW   = 2'b10;
  localparam logic [1:0] REGION_NONE = 2'b11;

  function automatic src_t func_src(input func_t f);
    case (f)
      F_RD_ROM, F_ROM2RAM, F_ROM2LED: return SRC_ROM;
      F_RD_RAM, F_RAM2LED:            return SRC_RAM;
      default:                        return SRC_SW;
    endcase
  endfunction

  function automatic logic func_to_ram(input func_t f);
    return (f == F_SW2RAM) || (f == F_ROM2RAM);
  endfunction

endpackage

// File: rtl/playbus_dec.sv
// Combinational source-enable decoder: live FUNC/ADD while idle, latched FUNC
// for the whole of an operation.
module playbus_dec
  import playbus_pkg::*;
(
  input  state_t     i_state,
  input  func_t      i_func_live,
  input  func_t      i_func_lat,
  input  logic [1:0] i_region,
  input  logic       i_go,
  output logic       o_n_romo,
  output logic       o_n_ramo,
  output logic       o_n_swben
);

  src_t w_src;

  always_comb begin
    w_src = SRC_NONE;
    if (i_state != ST_IDLE) begin
      w_src = func_src(i_func_lat);
    end else if (i_go) begin
      w_src = func_src(i_func_live);
    end else begin
      case (i_region)
        REGION_ROM:  w_src = SRC_ROM;
        REGION_RAM:  w_src = SRC_RAM;
        REGION_SW:   w_src = SRC_SW;
        REGION_NONE: w_src = SRC_NONE;
        default:     w_src = SRC_NONE;
      endcase
    end
  end

  assign o_n_romo  = (w_src != SRC_ROM);
  assign o_n_ramo  = (w_src != SRC_RAM);
  assign o_n_swben = (w_src != SRC_SW);

endmodule

// File: rtl/playbus_burst.sv
// Play-bus burst transfer controller: SOURCE/WRITE/HOLD sequencing per word.
// Define PLAYBUS_BURST_EN to honour LEN (LEN+1 words per GO); otherwise one word.
module playbus_burst
  import playbus_pkg::*;
#(
  parameter int AW       = 4,
  parameter int WR_CYC   = 1,
  parameter int HOLD_CYC = 1
) (
  input  logic          CK2HZ,
  input  logic          CLR,
  input  logic          GO,
  input  logic [2:0]    FUNC,
  input  logic [AW-1:0] ADD,
  input  logic [AW-1:0] LEN,
  output logic          n_ROMO,
  output logic          n_RAMO,
  output logic          n_SWBEN,
  output logic          n_RAMW,
  output logic          LEDLTCH,
  output logic [AW-1:0] ADDR,
  output logic          BUSY,
  output logic          DONE,
  output logic [2:0]    St
);

  localparam logic [3:0] WR_LAST   = 4'(WR_CYC - 1);
  localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYC - 1);

  state_t        r_state;
  func_t         r_func;
  logic [AW-1:0] r_addr;
  logic [3:0]    r_tcnt;
  logic          r_ramw;
  logic          r_ledltch;
  logic          r_done;

  state_t w_next;
  logic   w_latch;
  logic   w_advance;
  logic   w_finish;
  logic   w_cnt_zero;
  func_t  w_func_live;

`ifdef PLAYBUS_BURST_EN
  logic [AW-1:0] r_cnt;

  always_ff @(posedge CK2HZ or posedge CLR) begin
    if (CLR)            r_cnt <= '0;
    else if (w_latch)   r_cnt <= LEN;
    else if (w_advance) r_cnt <= r_cnt - 1'b1;
  end

  assign w_cnt_zero = (r_cnt == '0);
`else
  logic [AW-1:0] w_unused_len;
  assign w_unused_len = LEN;
  assign w_cnt_zero   = 1'b1;
`endif

  assign w_func_live = func_t'(FUNC);

  always_comb begin
    w_next    = r_state;
    w_latch   = 1'b0;
    w_advance = 1'b0;
    w_finish  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (GO && (FUNC >= 3'd3)) begin
          w_next  = ST_SOURCE;
          w_latch = 1'b1;
        end
      end
      ST_SOURCE: w_next = ST_WRITE;
      ST_WRITE: begin
        if (r_tcnt == WR_LAST) w_next = ST_HOLD;
      end
      ST_HOLD: begin
        if (r_tcnt == HOLD_LAST) begin
          if (w_cnt_zero) begin
            w_next   = ST_WAIT_GO;
            w_finish = 1'b1;
          end else begin
            w_next    = ST_SOURCE;
            w_advance = 1'b1;
          end
        end
      end
      ST_WAIT_GO: begin
        if (!GO) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Timer restarts on every state change; strobes follow the WRITE state exactly.
  always_ff @(posedge CK2HZ or posedge CLR) begin
    if (CLR) begin
      r_state   <= ST_IDLE;
      r_func    <= F_RD_ROM;
      r_addr    <= '0;
      r_tcnt    <= '0;
      r_ramw    <= 1'b0;
      r_ledltch <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_tcnt    <= (w_next != r_state) ? 4'd0 : r_tcnt + 4'd1;
      r_ramw    <= (w_next == ST_WRITE) &&  func_to_ram(r_func);
      r_ledltch <= (w_next == ST_WRITE) && !func_to_ram(r_func);
      r_done    <= w_finish;
      if (w_latch) begin
        r_func <= w_func_live;
        r_addr <= ADD;
      end else if (w_advance) begin
        r_addr <= r_addr + 1'b1;
      end
    end
  end

  playbus_dec u_dec (
    .i_state     (r_state),
    .i_func_live (w_func_live),
    .i_func_lat  (r_func),
    .i_region    (ADD[AW-1:AW-2]),
    .i_go        (GO),
    .o_n_romo    (n_ROMO),
    .o_n_ramo    (n_RAMO),
    .o_n_swben   (n_SWBEN)
  );

  assign St      = r_state;
  assign BUSY    = (r_state != ST_IDLE);
  assign DONE    = r_done;
  assign n_RAMW  = ~r_ramw;
  assign LEDLTCH = r_ledltch;
  assign ADDR    = ((r_state == ST_IDLE) && !CLR) ? ADD : r_addr;

endmodule

// File: tb/tb_playbus_burst.sv
// Scoreboard bench for playbus_burst: operations push expected strobe/DONE
// events, a negedge monitor pops and compares them.
module tb_playbus_burst;

  localparam int AW       = 4;
  localparam int WR_CYC   = 1;
  localparam int HOLD_CYC = 1;
`ifdef PLAYBUS_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  localparam int K_RAM  = 0;
  localparam int K_LED  = 1;
  localparam int K_DONE = 2;

  logic          CK2HZ = 1'b0;
  logic          CLR   = 1'b1;
  logic          GO    = 1'b0;
  logic [2:0]    FUNC  = 3'd0;
  logic [AW-1:0] ADD   = '0;
  logic [AW-1:0] LEN   = '0;
  logic          n_ROMO, n_RAMO, n_SWBEN, n_RAMW, LEDLTCH, BUSY, DONE;
  logic [AW-1:0] ADDR;
  logic [2:0]    St;

  playbus_burst #(.AW(AW), .WR_CYC(WR_CYC), .HOLD_CYC(HOLD_CYC)) dut (
    .CK2HZ(CK2HZ), .CLR(CLR), .GO(GO), .FUNC(FUNC), .ADD(ADD), .LEN(LEN),
    .n_ROMO(n_ROMO), .n_RAMO(n_RAMO), .n_SWBEN(n_SWBEN), .n_RAMW(n_RAMW),
    .LEDLTCH(LEDLTCH), .ADDR(ADDR), .BUSY(BUSY), .DONE(DONE), .St(St)
  );

  always #5 CK2HZ = ~CK2HZ;

  typedef struct {
    int            kind;
    logic [AW-1:0] addr;
  } ev_t;

  ev_t        exp_q[$];
  int         vectors     = 0;
  int         miscompares = 0;
  bit         mon_en      = 1'b0;
  logic [2:0] cur_func    = 3'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // {n_ROMO,n_RAMO,n_SWBEN} for a transfer's source: 3,5 SW; 4,6 ROM; 7 RAM
  function automatic logic [2:0] xfer_en(input logic [2:0] f);
    if (f == 3'd3 || f == 3'd5) return 3'b110;
    if (f == 3'd4 || f == 3'd6) return 3'b011;
    return 3'b101;
  endfunction

  function automatic logic [2:0] idle_en(input logic go, input logic [2:0] f, input logic [AW-1:0] a);
    int region;
    if (go) begin
      if (f == 3'd0) return 3'b011;
      if (f == 3'd1) return 3'b101;
      if (f == 3'd2) return 3'b110;
      return xfer_en(f);
    end
    region = int'(a) / (1 << (AW - 2));
    if (region == 0) return 3'b011;
    if (region == 1) return 3'b101;
    if (region == 2) return 3'b110;
    return 3'b111;
  endfunction

  always @(negedge CK2HZ) begin : monitor
    ev_t e;
    int  act_kind;
    if (mon_en && !CLR) begin
      if (!n_RAMW || LEDLTCH || DONE) begin
        chk("strobe_exclusive", {31'd0, (!n_RAMW && LEDLTCH)}, 32'd0);
        act_kind = DONE ? K_DONE : (!n_RAMW ? K_RAM : K_LED);
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_event: got kind %0d at ADDR %0h, expected none", act_kind, ADDR);
        end else begin
          e = exp_q.pop_front();
          chk("event_kind", act_kind, e.kind);
          if (e.kind != K_DONE) chk("event_addr", ADDR, e.addr);
        end
      end
      if (BUSY) chk("busy_src_en", {n_ROMO, n_RAMO, n_SWBEN}, xfer_en(cur_func));
    end
  end

  task automatic run_op(input logic [2:0] f, input logic [AW-1:0] a, input logic [AW-1:0] l,
                        input int go_hold, input int chg_cyc, input logic [2:0] chg_func);
    int n;
    int bound;
    logic [AW-1:0] ea;
    n = BURST ? int'(l) + 1 : 1;
    cur_func = f;
    for (int i = 0; i < n; i++) begin
      ea = a + AW'(i);
      for (int k = 0; k < WR_CYC; k++)
        exp_q.push_back('{kind: ((f == 3'd3 || f == 3'd4) ? K_RAM : K_LED), addr: ea});
    end
    exp_q.push_back('{kind: K_DONE, addr: '0});

    @(posedge CK2HZ); #1;
    GO = 1'b1; FUNC = f; ADD = a; LEN = l;
    for (int c = 1; c <= go_hold; c++) begin
      @(posedge CK2HZ); #1;
      if (c == 1) chk("busy_after_go", {31'd0, BUSY}, 32'd1);
      if (n == 1 && c <= 4) chk("state_sequence", St, c);
      if (c == chg_cyc) begin
        FUNC = chg_func; ADD = AW'($urandom); LEN = AW'($urandom);
      end
    end
    GO = 1'b0;
    if (go_hold >= 3 * n + 1) begin
      @(posedge CK2HZ); #1;
      chk("idle_one_clock_after_go_low", St, 0);
    end else begin
      bound = 0;
      while (St != 3'd0 && bound < 400) begin
        @(posedge CK2HZ); #1;
        bound++;
      end
      chk("return_to_idle", St, 0);
    end
    @(posedge CK2HZ); #1;
    chk("stays_idle", St, 0);
    chk("events_outstanding", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [AW-1:0] a;
    logic [2:0]    f;
    ADD = 4'hA;
    repeat (2) @(posedge CK2HZ);
    #1;
    chk("reset_St", St, 0);
    chk("reset_n_RAMW", {31'd0, n_RAMW}, 32'd1);
    chk("reset_LEDLTCH", {31'd0, LEDLTCH}, 32'd0);
    chk("reset_DONE", {31'd0, DONE}, 32'd0);
    chk("reset_BUSY", {31'd0, BUSY}, 32'd0);
    chk("reset_ADDR", ADDR, 0);
    CLR = 1'b0;
    #1;
    chk("post_reset_ADDR", ADDR, 32'hA);
    chk("post_reset_en", {n_ROMO, n_RAMO, n_SWBEN}, 3'b110);

    // CLR in the middle of a ROM->RAM write
    @(posedge CK2HZ); #1;
    GO = 1'b1; FUNC = 3'd4; ADD = 4'd9; LEN = '0;
    @(posedge CK2HZ); #1;
    chk("midwrite_source", St, 1);
    @(posedge CK2HZ); #1;
    chk("midwrite_write", St, 2);
    chk("midwrite_ramw_active", {31'd0, n_RAMW}, 32'd0);
    CLR = 1'b1;
    #1;
    chk("clr_n_RAMW", {31'd0, n_RAMW}, 32'd1);
    chk("clr_St", St, 0);
    chk("clr_ADDR", ADDR, 0);
    chk("clr_BUSY", {31'd0, BUSY}, 32'd0);
    GO = 1'b0;
    @(posedge CK2HZ); #1;
    CLR = 1'b0;
    @(posedge CK2HZ); #1;
    chk("after_clr_St", St, 0);
    mon_en = 1'b1;

    // Static reads and idle decode
    GO = 1'b1; FUNC = 3'd1; ADD = 4'd5;
    #1;
    chk("static_en", {n_ROMO, n_RAMO, n_SWBEN}, 3'b101);
    chk("static_ADDR", ADDR, 5);
    @(posedge CK2HZ); #1;
    chk("static_St", St, 0);
    for (int i = 0; i < 12; i++) begin
      a = AW'($urandom);
      f = 3'($urandom_range(0, 2));
      GO = i[0]; FUNC = f; ADD = a;
      #2;
      chk("idle_en", {n_ROMO, n_RAMO, n_SWBEN}, idle_en(GO, f, a));
      chk("idle_ADDR", ADDR, a);
      @(posedge CK2HZ); #1;
      chk("idle_St", St, 0);
    end
    GO = 1'b0;

    run_op(3'd6, 4'd3, 4'd0, 10, 0, 3'd0);
    run_op(3'd3, 4'd14, 4'd2, 12, 0, 3'd0);
    run_op(3'd4, 4'd7, 4'd1, 12, 2, 3'd7);

    for (int i = 0; i < 25; i++) begin
      run_op(3'($urandom_range(3, 7)), AW'($urandom), AW'($urandom),
             $urandom_range(1, 30), $urandom_range(0, 3), 3'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
